// File: rtl/keypad_scanner_n_if.sv
// Pin and status bundle between the keypad matrix, the scanner and its consumer.
// master = scanner side; slave = board pins plus game-fsm side.
interface keypad_scanner_n_if #(
  parameter int ROWS  = 4,
  parameter int COLS  = 4,
  parameter int KEY_W = 5
);
  logic [COLS-1:0]  columna;
  logic [ROWS-1:0]  fila;
  logic [KEY_W-1:0] key;
  logic             keypad_pressed;
  logic             key_valid;
  logic             multi_key;

  modport master (
    input  columna,
    output fila, key, keypad_pressed, key_valid, multi_key
  );

  modport slave (
    output columna,
    input  fila, key, keypad_pressed, key_valid, multi_key
  );
endinterface

// File: rtl/keypad_scanner_n.sv
// ROWS x COLS matrix keypad scanner with debounce, latched key code and multi-key flag.
// Optional auto-repeat of key_valid while held: define KEYPAD_REPEAT_EN.
module keypad_scanner_n #(
  parameter int ROWS          = 4,
  parameter int COLS          = 4,
  parameter int KEY_W         = 5,
  parameter int SCAN_DIV      = 1000,
  parameter int DEBOUNCE      = 4,
  parameter int REPEAT_FRAMES = 50
) (
  input  logic                clk,
  input  logic                rst,
  keypad_scanner_n_if.master  kp
);

  localparam int DW_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int ROW_W = $clog2(ROWS);
  localparam int DC_W  = $clog2(DEBOUNCE + 1);
  localparam logic [KEY_W-1:0] NO_KEY = '1;

  // Elaboration-time guards on the parameter ranges.
  if (2 ** KEY_W <= ROWS * COLS) begin : g_bad_key_w
    $error("keypad_scanner_n: KEY_W too small for ROWS*COLS codes plus NO_KEY");
  end
  if (SCAN_DIV < 4 || DEBOUNCE < 1 || REPEAT_FRAMES < 1) begin : g_bad_timing
    $error("keypad_scanner_n: SCAN_DIV >= 4, DEBOUNCE >= 1, REPEAT_FRAMES >= 1 required");
  end

  typedef enum logic [1:0] {IDLE, DEB, HELD, REL} state_e;

  // Two-flop synchroniser for the asynchronous column pins.
  logic [COLS-1:0]  col_s1_q, col_s2_q;

  logic [DW_W-1:0]  dwell_q, dwell_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [ROWS-1:0]  fila_q, fila_d;

  // Per-frame accumulators, cleared at each frame end.
  logic             found_q, found_d;
  logic [KEY_W-1:0] acc_cand_q, acc_cand_d;
  logic [1:0]       cnt_q, cnt_d;
  logic             seen_q, seen_d;

  state_e           state_q, state_d;
  logic [KEY_W-1:0] cand_q, cand_d;
  logic [DC_W-1:0]  dctr_q, dctr_d;
  logic [KEY_W-1:0] key_q, key_d;
  logic             pressed_q, pressed_d;
  logic             valid_q, valid_d;
  logic             multi_q, multi_d;

`ifdef KEYPAD_REPEAT_EN
  localparam int REP_W = $clog2(REPEAT_FRAMES + 1);
  logic [REP_W-1:0] rep_q, rep_d;
`endif

  function automatic logic [KEY_W-1:0] code_of(input logic [ROW_W-1:0] r, input int c);
    return KEY_W'(int'(r) * COLS + c);
  endfunction

  logic             sample, last_row, frame_end;
  logic [COLS-1:0]  pressed_row;
  logic             row_found, row_seen;
  logic [KEY_W-1:0] row_code;
  logic [1:0]       row_cnt;
  logic             f_found, f_seen;
  logic [KEY_W-1:0] f_cand;
  logic [2:0]       cnt_sum;
  logic [1:0]       f_cnt;

  // NOTE: every always_comb output gets a default first, so no path leaves a latch.
  always_comb begin
    sample      = (dwell_q == DW_W'(SCAN_DIV - 1));
    last_row    = (row_q == ROW_W'(ROWS - 1));
    frame_end   = sample && last_row;
    pressed_row = ~col_s2_q;

    // Descending scan leaves the lowest pressed column as row_code.
    row_found = 1'b0;
    row_seen  = 1'b0;
    row_code  = '0;
    row_cnt   = '0;
    for (int c = COLS - 1; c >= 0; c--) begin
      if (pressed_row[c]) begin
        row_found = 1'b1;
        row_code  = code_of(row_q, c);
        if (row_cnt != 2'd2) row_cnt = row_cnt + 2'd1;
        if (code_of(row_q, c) == key_q) row_seen = 1'b1;
      end
    end

    f_found = found_q | row_found;
    f_cand  = found_q ? acc_cand_q : row_code;
    f_seen  = seen_q | row_seen;
    cnt_sum = {1'b0, cnt_q} + {1'b0, row_cnt};
    f_cnt   = (cnt_sum > 3'd2) ? 2'd2 : cnt_sum[1:0];

    dwell_d    = sample ? '0 : dwell_q + DW_W'(1);
    row_d      = row_q;
    fila_d     = fila_q;
    found_d    = found_q;
    acc_cand_d = acc_cand_q;
    cnt_d      = cnt_q;
    seen_d     = seen_q;
    if (sample) begin
      row_d  = last_row ? '0 : row_q + ROW_W'(1);
      fila_d = ~(ROWS'(1) << row_d);
      if (last_row) begin
        found_d    = 1'b0;
        acc_cand_d = '0;
        cnt_d      = '0;
        seen_d     = 1'b0;
      end else begin
        found_d    = f_found;
        acc_cand_d = f_cand;
        cnt_d      = f_cnt;
        seen_d     = f_seen;
      end
    end

    state_d   = state_q;
    cand_d    = cand_q;
    dctr_d    = dctr_q;
    key_d     = key_q;
    pressed_d = pressed_q;
    valid_d   = 1'b0;
    multi_d   = multi_q;
`ifdef KEYPAD_REPEAT_EN
    rep_d     = rep_q;
`endif

    if (frame_end) begin
      multi_d = (f_cnt > 2'd1);
`ifdef KEYPAD_REPEAT_EN
      // Any frame that does not stay in HELD restarts the repeat count.
      rep_d = '0;
`endif
      unique case (state_q)
        IDLE: begin
          if (f_found) begin
            cand_d = f_cand;
            dctr_d = DC_W'(1);
            if (DEBOUNCE == 1) begin
              state_d   = HELD;
              key_d     = f_cand;
              pressed_d = 1'b1;
              valid_d   = 1'b1;
            end else begin
              state_d = DEB;
            end
          end
        end
        DEB: begin
          if (!f_found) begin
            state_d = IDLE;
          end else if (f_cand == cand_q) begin
            dctr_d = dctr_q + DC_W'(1);
            if (dctr_d == DC_W'(DEBOUNCE)) begin
              state_d   = HELD;
              key_d     = cand_q;
              pressed_d = 1'b1;
              valid_d   = 1'b1;
            end
          end else begin
            cand_d = f_cand;
            dctr_d = DC_W'(1);
          end
        end
        HELD: begin
          if (f_seen) begin
`ifdef KEYPAD_REPEAT_EN
            rep_d = rep_q + REP_W'(1);
            if (rep_d == REP_W'(REPEAT_FRAMES)) begin
              rep_d   = '0;
              valid_d = 1'b1;
            end
`endif
          end else if (DEBOUNCE == 1) begin
            state_d   = IDLE;
            key_d     = NO_KEY;
            pressed_d = 1'b0;
          end else begin
            state_d = REL;
            dctr_d  = DC_W'(1);
          end
        end
        REL: begin
          if (f_seen) begin
            state_d = HELD;
          end else begin
            dctr_d = dctr_q + DC_W'(1);
            if (dctr_d == DC_W'(DEBOUNCE)) begin
              state_d   = IDLE;
              key_d     = NO_KEY;
              pressed_d = 1'b0;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments and every flop has the async reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_s1_q   <= '1;
      col_s2_q   <= '1;
      dwell_q    <= '0;
      row_q      <= '0;
      fila_q     <= ~ROWS'(1);
      found_q    <= 1'b0;
      acc_cand_q <= '0;
      cnt_q      <= '0;
      seen_q     <= 1'b0;
      state_q    <= IDLE;
      cand_q     <= '0;
      dctr_q     <= '0;
      key_q      <= NO_KEY;
      pressed_q  <= 1'b0;
      valid_q    <= 1'b0;
      multi_q    <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      rep_q      <= '0;
`endif
    end else begin
      col_s1_q   <= kp.columna;
      col_s2_q   <= col_s1_q;
      dwell_q    <= dwell_d;
      row_q      <= row_d;
      fila_q     <= fila_d;
      found_q    <= found_d;
      acc_cand_q <= acc_cand_d;
      cnt_q      <= cnt_d;
      seen_q     <= seen_d;
      state_q    <= state_d;
      cand_q     <= cand_d;
      dctr_q     <= dctr_d;
      key_q      <= key_d;
      pressed_q  <= pressed_d;
      valid_q    <= valid_d;
      multi_q    <= multi_d;
`ifdef KEYPAD_REPEAT_EN
      rep_q      <= rep_d;
`endif
    end
  end

  assign kp.fila           = fila_q;
  assign kp.key            = key_q;
  assign kp.keypad_pressed = pressed_q;
  assign kp.key_valid      = valid_q;
  assign kp.multi_key      = multi_q;

endmodule
